// File: rtl/trdb_packet_fifo.sv
// Trace packet FIFO: first-word-fall-through buffer between the trace encoder and its sink,
// with a sticky overflow flag and a one-cycle watermark pulse.
module trdb_packet_fifo #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [XLEN-1:0]          packet_word_i,
  input  logic                     packet_word_valid_i,
  output logic                     grant_o,
  output logic [XLEN-1:0]          data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o,
  output logic                     threshold_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] THR = (AW + 1)'(THRESHOLD);

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] fill_next;
  logic        overflow_reg;
  logic        threshold_reg;
  logic        empty, full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign grant_o = !full;
  assign push    = packet_word_valid_i && !full && !flush_i;
  assign pop     = !empty && ready_i && !flush_i;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    fill_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      threshold_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      // Rising-crossing detect; flush forces fill_next to 0 so it never pulses.
      threshold_reg <= (fill_o < THR) && (fill_next >= THR);
      if (flush_i)
        overflow_reg <= 1'b0;
      else if (packet_word_valid_i && full)
        overflow_reg <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; data_o is only meaningful with valid_o.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= packet_word_i;
  end

  assign data_o      = mem[rd_ptr_reg[AW-1:0]];
  assign valid_o     = !empty;
  assign fill_o      = wr_ptr_reg - rd_ptr_reg;
  assign overflow_o  = overflow_reg;
  assign threshold_o = threshold_reg;

endmodule

// File: tb/tb_trdb_packet_fifo.sv
// Bench for trdb_packet_fifo (DEPTH=4, THRESHOLD=3): queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_trdb_packet_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [XLEN-1:0] word;
  logic            word_valid;
  logic            grant;
  logic [XLEN-1:0] data;
  logic            valid;
  logic            ready;
  logic [2:0]      fill;
  logic            overflow;
  logic            threshold;

  trdb_packet_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .packet_word_i       (word),
    .packet_word_valid_i (word_valid),
    .grant_o             (grant),
    .data_o              (data),
    .valid_o             (valid),
    .ready_i             (ready),
    .fill_o              (fill),
    .overflow_o          (overflow),
    .threshold_o         (threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int thr_seen    = 0;
  int step_no     = 0;

  // Reference model: contents as a plain queue plus two flags.
  logic [XLEN-1:0] mq[$];
  logic            m_ovf = 1'b0;
  logic            m_thr = 1'b0;

  logic [XLEN-1:0] out_log[$];
  logic [XLEN-1:0] exp_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_thr = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_thr = 1'b0;
    end else begin
      int old_n;
      bit was_full;
      old_n    = mq.size();
      was_full = (old_n == DEPTH);
      if (old_n != 0 && ready) void'(mq.pop_front());
      if (word_valid && !was_full) mq.push_back(word);
      if (word_valid && was_full) m_ovf = 1'b1;
      m_thr = (old_n < THR) && (mq.size() >= THR);
    end
  end

  // Record what the consumer actually takes.
  always @(posedge clk) begin
    if (rst_n && valid && ready && !flush) out_log.push_back(data);
  end

  always @(negedge clk) begin
    check("grant", 32'(grant), 32'(mq.size() != DEPTH));
    check("valid", 32'(valid), 32'(mq.size() != 0));
    check("fill", 32'(fill), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("threshold", 32'(threshold), 32'(m_thr));
    if (mq.size() != 0) check("data", data, mq[0]);
    if (threshold) thr_seen++;
  end

  task automatic step(input logic v, input logic [XLEN-1:0] w, input logic r, input logic f);
    word_valid = v;
    word       = w;
    ready      = r;
    flush      = f;
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d: valid=%0b word=0x%0h ready=%0b flush=%0b -> fill=%0d valid_o=%0b ovf=%0b",
             step_no, v, w, r, f, fill, valid, overflow);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 32'(out_log.size()), 32'(exp_log.size()));
    if (out_log.size() == exp_log.size())
      foreach (exp_log[i]) check({name, "_word"}, out_log[i], exp_log[i]);
    out_log.delete();
    exp_log.delete();
  endtask

  initial begin
    int base;
    rst_n = 1'b0; flush = 1'b0; word = '0; word_valid = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd1);
    check("reset_fill", 32'(fill), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // In-order transfer with a single watermark pulse.
    base = thr_seen;
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + 32'(i), 0, 0);
    step(0, 0, 0, 0);
    check("full_fill", 32'(fill), 32'd4);
    check("full_grant", 32'(grant), 32'd0);
    check("thr_once", 32'(thr_seen - base), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    check("drained_fill", 32'(fill), 32'd0);
    exp_log = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check_log("order");

    // Overflow while full; dropped word must never appear.
    for (int i = 0; i < 4; i++) step(1, 32'hE0 + 32'(i), 0, 0);
    step(1, 32'hBB, 0, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    exp_log = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    check_log("ovf_drain");

    // Full with simultaneous pop and presented word: pop only.
    for (int i = 0; i < 4; i++) step(1, 32'hF0 + 32'(i), 0, 0);
    step(1, 32'h99, 1, 0);
    check("fullpp_fill", 32'(fill), 32'd3);
    check("fullpp_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    exp_log = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    check_log("fullpp");

    // Flush with a presented word.
    for (int i = 1; i <= 3; i++) step(1, 32'hC0 + 32'(i), 0, 0);
    check("preflush_fill", 32'(fill), 32'd3);
    check("preflush_ovf", 32'(overflow), 32'd1);
    step(1, 32'hCC, 1, 1);
    base = thr_seen;
    check("flush_fill", 32'(fill), 32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    step(0, 0, 1, 0);
    check("flush_nothr", 32'(thr_seen - base), 32'd0);
    check_log("flush");

    // Wrap-around at steady fill 2.
    base = thr_seen;
    step(1, 32'h10, 0, 0);
    step(1, 32'h11, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h20 + 32'(i), 1, 0);
    check("wrap_fill", 32'(fill), 32'd2);
    check("wrap_nothr", 32'(thr_seen - base), 32'd0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    exp_log = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25,
                32'h26, 32'h27, 32'h28, 32'h29};
    check_log("wrap");

    // Asynchronous reset mid-stream.
    step(1, 32'h51, 0, 0);
    step(1, 32'h52, 0, 0);
    check("prerst_fill", 32'(fill), 32'd2);
    word_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_thr", 32'(threshold), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 32'hD1, 0, 0);
    check("post_rst_data", data, 32'hD1);
    check("post_rst_valid", 32'(valid), 32'd1);
    step(0, 0, 1, 0);
    exp_log = '{32'hD1};
    check_log("post_rst");

    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trdb_packet_fifo.md
TRDB_PACKET_FIFO -- requirements
Module: trdb_packet_fifo

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of a packet word.
REQ-002 SHALL have parameter DEPTH, default 16, number of word entries; power of two, >= 2.
REQ-003 SHALL have parameter THRESHOLD, default 8, fill level that raises the watermark pulse; 1..DEPTH.
REQ-004 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  synchronous clear of contents and overflow flag.
REQ-007 SHALL have port packet_word_i  in  XLEN  packet word from the trace encoder.
REQ-008 SHALL have port packet_word_valid_i  in  1  packet_word_i is valid this cycle.
REQ-009 SHALL have port grant_o  out  1  word is accepted this cycle if packet_word_valid_i is high.
REQ-010 SHALL have port data_o  out  XLEN  oldest stored word.
REQ-011 SHALL have port valid_o  out  1  data_o holds a stored word.
REQ-012 SHALL have port ready_i  in  1  consumer takes data_o when valid_o is high.
REQ-013 SHALL have port fill_o  out  $clog2(DEPTH)+1  current number of stored words.
REQ-014 SHALL have port overflow_o  out  1  sticky flag: a valid word was dropped.
REQ-015 SHALL have port threshold_o  out  1  one-cycle pulse when fill reaches THRESHOLD.

Function
REQ-016 SHALL store words in a DEPTH-entry memory with read/write pointers of $clog2(DEPTH)+1 bits; pointers wrap modulo 2*DEPTH.
REQ-017 SHALL detect empty when pointers are equal and full when the index bits are equal and the MSBs differ.
REQ-018 SHALL drive grant_o = !full combinationally; no path from packet_word_valid_i or ready_i to grant_o.
REQ-019 SHALL accept (push) a word when packet_word_valid_i && grant_o && !flush_i; the word is written at the write pointer and the pointer increments at that edge.
REQ-020 SHALL drive valid_o = !empty and data_o = mem[read index], first-word-fall-through; a word pushed at edge N is visible on data_o/valid_o after edge N.
REQ-021 SHALL pop when valid_o && ready_i && !flush_i; the read pointer increments at that edge.
REQ-022 SHALL hold data_o and valid_o stable while valid_o && !ready_i, except on flush or reset.
REQ-023 SHALL allow push and pop in the same cycle when neither empty nor full; fill_o is then unchanged.
REQ-024 SHALL when full, refuse the push even if a pop occurs in the same cycle (grant_o stays low for that cycle).
REQ-025 SHALL when empty, accept the push and perform no pop that cycle.
REQ-026 SHALL drive fill_o = write pointer - read pointer, modulo 2*DEPTH, range 0..DEPTH.
REQ-027 SHALL set overflow_o at the edge after any cycle with packet_word_valid_i && !grant_o && !flush_i; the word is dropped; overflow_o stays high until flush or reset.
REQ-028 SHALL pulse threshold_o for exactly one cycle, the cycle after the edge at which fill goes from below THRESHOLD to THRESHOLD or above; a later climb after dropping below THRESHOLD pulses again.
REQ-029 SHALL give flush_i priority over push and pop: at the edge both pointers return to 0 and overflow_o clears.
REQ-030 SHALL on a flush cycle drop any presented word without setting overflow_o and without a threshold_o pulse.

Reset
REQ-031 SHALL on rst_ni low asynchronously clear pointers, overflow_o and threshold_o, giving grant_o=1, valid_o=0, fill_o=0, overflow_o=0, threshold_o=0.
REQ-032 SHALL leave memory contents unreset; data_o is don't-care while valid_o=0.
REQ-033 SHALL on reset asserted mid-stream discard all stored words; the first push after release is the first word out.

Verification (DEPTH=4, THRESHOLD=3)
REQ-034 SHALL verify in-order transfer: push 0xA0..0xA3 with ready_i=0 -> fill_o=4, grant_o=0, threshold_o pulses once after the third push; then ready_i=1 -> data_o 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; fill_o returns to 0.
REQ-035 SHALL verify overflow: while full, present 0xBB -> overflow_o=1 next cycle, 0xBB never appears on data_o; overflow_o stays 1 after draining.
REQ-036 SHALL verify full with simultaneous pop and push: full, ready_i=1 and valid in -> one pop, no push, fill_o=3, overflow_o=1.
REQ-037 SHALL verify wrap-around: 10 push/pop pairs at fill 2 -> output order matches input, fill_o stays 2, no threshold_o pulse.
REQ-038 SHALL verify flush: fill_o=3, overflow_o=1, flush_i with valid word 0xCC -> next cycle fill_o=0, valid_o=0, overflow_o=0; 0xCC never output.
REQ-039 SHALL verify reset mid-operation: rst_ni low with fill_o=2 -> outputs at reset values immediately; after release push 0xD1 -> data_o=0xD1, valid_o=1.
